// File: rtl/input_receiver.sv
// input_receiver: pin-side receiver for the 4-phase byte handshake.
// Synchronizes the user strobe, captures one byte per handshake into a
// small FIFO and presents queued bytes to the cipher core via valid/ready.
//
// state | meaning
// IDLE  | waiting for a synchronized strobe with room in the FIFO
// ACK   | byte captured, acknowledge held until the strobe is seen low

module input_receiver #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          pin_data_in,
    input  logic                       input_valid,
    output logic                       input_acknowledged,
    output logic [DATA_W-1:0]          byte_out,
    output logic                       byte_valid,
    input  logic                       byte_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       rx_stalled
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               ack_q, ack_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic valid_s;
    logic full;
    logic push;
    logic pop;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign valid_s = input_valid;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q, sync_d;

            // Shift the asynchronous strobe one stage further along the chain
            always_comb begin
                sync_d    = sync_q;
                sync_d[0] = input_valid;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            // Synchronizer flops, cleared on reset so a held strobe is re-seen
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign valid_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign full       = (count_q == CNT_W'(DEPTH));
    assign pop        = (count_q != '0) && byte_ready;
    assign push       = (state_q == IDLE) && valid_s && !full;
    assign rx_stalled = (state_q == IDLE) && valid_s && full;

    assign byte_valid         = (count_q != '0);
    assign byte_out           = mem_q[rd_ptr_q];
    assign fifo_count         = count_q;
    assign input_acknowledged = ack_q;

    // Next-state for the handshake FSM and FIFO bookkeeping
    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!valid_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ack_d = (state_d == ACK);

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // FSM state, registered acknowledge and FIFO pointers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are irrelevant once the count is cleared
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pin_data_in;
        end
    end

endmodule

// File: tb/tb_input_receiver.sv
// Bench for input_receiver: directed handshake scenarios followed by a
// randomized protocol-respecting user, all checked against a queue model.

module tb_input_receiver;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] pin_data_in;
    logic          input_valid;
    logic          input_acknowledged;
    logic [DW-1:0] byte_out;
    logic          byte_valid;
    logic          byte_ready;
    logic [CW-1:0] fifo_count;
    logic          rx_stalled;

    int compared   = 0;
    int mismatched = 0;
    int max_cnt    = 0;

    // reference model state
    logic [DW-1:0] mq[$];
    bit            vq[$];
    bit            m_ack;

    input_receiver #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .DATA_W(DW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pin_data_in        (pin_data_in),
        .input_valid        (input_valid),
        .input_acknowledged (input_acknowledged),
        .byte_out           (byte_out),
        .byte_valid         (byte_valid),
        .byte_ready         (byte_ready),
        .fifo_count         (fifo_count),
        .rx_stalled         (rx_stalled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        vq.delete();
        for (int i = 0; i < SYNC; i++) vq.push_back(1'b0);
        m_ack = 1'b0;
    endtask

    // one clock edge: advance the model with the inputs seen at the edge, then compare
    task automatic tick();
        bit vs, vs_now, pop, push;
        int sz;
        sz   = mq.size();
        vs   = (SYNC == 0) ? input_valid : vq[0];
        pop  = (sz > 0) && byte_ready;
        push = !m_ack && vs && (sz < DEPTH);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(pin_data_in);
            if (m_ack && !vs) m_ack = 1'b0;
            else if (push)    m_ack = 1'b1;
            vq.push_back(input_valid);
            if (vq.size() > SYNC) void'(vq.pop_front());
        end
        #1;
        vs_now = (SYNC == 0) ? input_valid : vq[0];
        chk("ack", 32'(input_acknowledged), 32'(m_ack));
        chk("byte_valid", 32'(byte_valid), 32'(mq.size() != 0));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("rx_stalled", 32'(rx_stalled), 32'(!m_ack && vs_now && mq.size() == DEPTH));
        if (mq.size() != 0) chk("byte_out", 32'(byte_out), 32'(mq[0]));
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic handshake(input logic [DW-1:0] d);
        int n;
        pin_data_in = d;
        input_valid = 1'b1;
        n = 0;
        while (!input_acknowledged && n < 20) begin tick(); n++; end
        chk("hs_ack_rise", 32'(input_acknowledged), 32'd1);
        input_valid = 1'b0;
        n = 0;
        while (input_acknowledged && n < 20) begin tick(); n++; end
        chk("hs_ack_fall", 32'(input_acknowledged), 32'd0);
    endtask

    task automatic drain();
        int n;
        byte_ready = 1'b1;
        n = 0;
        while (byte_valid && n < 40) begin tick(); n++; end
        chk("drain_empty", 32'(byte_valid), 32'd0);
        byte_ready = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        pin_data_in = '0;
        input_valid = 1'b0;
        byte_ready  = 1'b0;
        model_reset();

        // reset state
        ticks(2);
        chk("rst_ack", 32'(input_acknowledged), 32'd0);
        chk("rst_bv", 32'(byte_valid), 32'd0);
        chk("rst_cnt", 32'(fifo_count), 32'd0);
        chk("rst_stall", 32'(rx_stalled), 32'd0);
        rst_n = 1'b1;
        tick();

        // capture latency: SYNC+1 edges
        pin_data_in = 8'hA5;
        input_valid = 1'b1;
        ticks(2);
        chk("lat_ack_early", 32'(input_acknowledged), 32'd0);
        tick();
        chk("lat_ack", 32'(input_acknowledged), 32'd1);
        chk("lat_bv", 32'(byte_valid), 32'd1);
        chk("lat_byte", 32'(byte_out), 32'hA5);
        chk("lat_cnt", 32'(fifo_count), 32'd1);
        input_valid = 1'b0;
        ticks(2);
        chk("rel_ack_early", 32'(input_acknowledged), 32'd1);
        tick();
        chk("rel_ack", 32'(input_acknowledged), 32'd0);
        drain();

        // fill, stall on the fifth, single pop releases it
        for (int k = 1; k <= 4; k++) handshake(DW'(k));
        pin_data_in = 8'h05;
        input_valid = 1'b1;
        ticks(6);
        chk("full_cnt", 32'(fifo_count), 32'd4);
        chk("full_stall", 32'(rx_stalled), 32'd1);
        chk("full_noack", 32'(input_acknowledged), 32'd0);
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        chk("pop_noack", 32'(input_acknowledged), 32'd0);
        chk("pop_cnt", 32'(fifo_count), 32'd3);
        tick();
        chk("late_ack", 32'(input_acknowledged), 32'd1);
        chk("late_cnt", 32'(fifo_count), 32'd4);
        input_valid = 1'b0;
        ticks(4);
        byte_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            chk("order", 32'(byte_out), 32'(k));
            tick();
        end
        byte_ready = 1'b0;
        chk("order_empty", 32'(byte_valid), 32'd0);

        // long held strobe yields exactly one byte
        pin_data_in = 8'h77;
        input_valid = 1'b1;
        ticks(20);
        chk("hold_cnt", 32'(fifo_count), 32'd1);
        input_valid = 1'b0;
        ticks(4);
        drain();

        // streaming with ready held high: wrap the pointers
        byte_ready = 1'b1;
        max_cnt = 0;
        for (int k = 16; k < 32; k++) handshake(DW'(k));
        ticks(2);
        chk("stream_max", 32'(max_cnt), 32'd1);
        byte_ready = 1'b0;

        // coincident push and pop at count 2
        handshake(8'h21);
        handshake(8'h22);
        pin_data_in = 8'h23;
        input_valid = 1'b1;
        ticks(2);
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        chk("co_cnt", 32'(fifo_count), 32'd2);
        chk("co_head", 32'(byte_out), 32'h22);
        input_valid = 1'b0;
        ticks(4);
        drain();

        // reset while in ACK with three queued bytes
        handshake(8'h31);
        handshake(8'h32);
        pin_data_in = 8'h33;
        input_valid = 1'b1;
        ticks(3);
        chk("pre_rst_cnt", 32'(fifo_count), 32'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_cnt", 32'(fifo_count), 32'd0);
        chk("mid_rst_bv", 32'(byte_valid), 32'd0);
        chk("mid_rst_ack", 32'(input_acknowledged), 32'd0);
        ticks(3);
        chk("recap_ack", 32'(input_acknowledged), 32'd1);
        chk("recap_byte", 32'(byte_out), 32'h33);
        chk("recap_cnt", 32'(fifo_count), 32'd1);
        input_valid = 1'b0;
        ticks(4);
        drain();

        // randomized 4-phase user and random consumer
        for (int i = 0; i < 600; i++) begin
            if (!input_valid && !input_acknowledged && $urandom_range(0, 2) == 0) begin
                pin_data_in = DW'($urandom);
                input_valid = 1'b1;
            end else if (input_valid && input_acknowledged && $urandom_range(0, 1) == 0) begin
                input_valid = 1'b0;
            end
            byte_ready = ($urandom_range(0, 3) == 0);
            tick();
        end
        input_valid = 1'b0;
        ticks(4);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/input_receiver.md
Name: input_receiver

Overview:
- Chip-pin receive side of the byte handshake that the output path drives in the opposite direction.
- The external user places a byte on the input pins and raises input_valid. This block synchronizes the strobe, captures the byte into a small FIFO, and raises input_acknowledged under a 4-phase handshake.
- It then presents the queued bytes to the stream cipher core through a valid/ready interface.
- It sits between the chip input pins and the cipher datapath.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- SYNC_STAGES, 2, flops on input_valid before use; 0 means used directly.
- DATA_W, 8, byte width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- pin_data_in  input  DATA_W  byte from chip user; held stable by the user while input_valid=1
- input_valid  input  1  user strobe, asynchronous to clk
- input_acknowledged  output  1  byte captured; stays high until input_valid is seen low
- byte_out  output  DATA_W  FIFO head toward the cipher core
- byte_valid  output  1  FIFO not empty
- byte_ready  input  1  cipher core consumes byte_out this cycle
- fifo_count  output  $clog2(DEPTH+1)  occupied entries
- rx_stalled  output  1  user is presenting a byte but the FIFO is full

Behaviour:
- Reset, checked at a clk edge with rst_n=0:
  - state=IDLE, FIFO pointers and count cleared, sync flops cleared.
  - input_acknowledged=0, byte_valid=0, fifo_count=0, rx_stalled=0.
  - byte_out is don't-care while byte_valid=0.
- valid_s is input_valid delayed through SYNC_STAGES flops; with SYNC_STAGES=0 it is combinational.
- FSM, two states:
  - IDLE, valid_s=1, full=0: write pin_data_in at the FIFO write pointer and go to ACK.
  - IDLE, valid_s=1, full=1: stay in IDLE with no write; rx_stalled=1 (combinational).
  - ACK, valid_s=0: return to IDLE.
  - ACK, valid_s=1: stay in ACK. No second capture occurs, so each handshake yields exactly one byte.
- input_acknowledged is registered and equals (state==ACK).
- Capture latency:
  - input_acknowledged rises SYNC_STAGES+1 clock edges after the first edge that samples input_valid=1.
  - If the FIFO was empty, byte_valid rises in the same cycle as input_acknowledged.
- Release latency: input_acknowledged falls SYNC_STAGES+1 edges after the first edge that samples input_valid=0.
- Downstream side:
  - byte_valid = (count!=0); byte_out = head entry (registered storage, read combinationally).
  - A pop happens on any edge with byte_valid && byte_ready.
- Full and empty:
  - full = (count==DEPTH). A pop in the same cycle does not unblock the push; the push waits one cycle.
  - byte_ready while empty has no effect.
- Simultaneous push and pop when not full and not empty: both happen and count is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count goes 0..DEPTH, never beyond.
- FIFO order is strict first in, first out; no bytes are dropped and none are duplicated.
- Reset in mid-operation:
  - All queued bytes are discarded and input_acknowledged drops the cycle after the reset edge.
  - If the user still holds input_valid=1 after reset releases, the byte is captured again once sync completes. This duplicate is intended, because the user never saw a completed handshake.

Test Plan:
- SYNC_STAGES=2, reset, then pin_data_in=0xA5 and input_valid=1 at edge 1:
  - input_acknowledged=1 and byte_valid=1 with byte_out=0xA5 after edge 3; fifo_count=1.
  - Drop input_valid: input_acknowledged=0 three edges later.
- Four handshakes 0x01,0x02,0x03,0x04 with byte_ready=0, then a fifth with 0x05:
  - fifo_count=4, rx_stalled=1, no ack for the fifth.
  - Pulse byte_ready for one cycle: pops 0x01, 0x05 is captured the next cycle, order out is 0x02..0x05.
- Hold input_valid=1 for 20 cycles: exactly one push and fifo_count=1.
- byte_ready=1 held permanently, stream 0x10..0x1F through 16 handshakes:
  - Outputs appear in order; pointer wrap is exercised; fifo_count never exceeds 1.
- Push and pop coincident at count=2: count stays 2 and head advances correctly.
- Assert rst_n=0 at count=3 while in ACK:
  - Next cycle count=0, byte_valid=0, input_acknowledged=0.
  - With input_valid still 1, the byte is re-captured after SYNC_STAGES+1 edges.
